ram_tdp_sync: RTL
=================

# ram_tdp_sync

Parametrised single-clock true-dual-port RAM. It supersedes the fixed 1K x 18 dual-port block RAM primitives in the array wrappers with configurable width, depth, parity, byte enables, read mode and output pipelining. It adds deterministic collision resolution and collision reporting. It sits under the cache and queue array wrappers as a synthesizable behavioural model and can be mapped onto vendor block RAM.

## Interface

Parameters:
- ADDR_W, 10, address width; depth = 2^ADDR_W
- DATA_W, 16, data bits per port; must be a multiple of 8
- PAR_W, 2, parity bits per port; must equal DATA_W/8 or 0
- READ_MODE, "WRITE_FIRST", one of "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE", applied to both ports
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency
- SRVAL, 0, value loaded on SSR into {DOP, DO}; width DATA_W+PAR_W

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous active-low reset
- ena, enb  in  1  port enable
- wea, web  in  DATA_W/8  byte write enables; byte i covers D[8i+7:8i] and DP[i]
- ssra, ssrb  in  1  synchronous output set/reset
- addra, addrb  in  ADDR_W  address
- dia, dib  in  DATA_W  write data
- dipa, dipb  in  PAR_W  write parity
- doa, dob  out  DATA_W  read data
- dopa, dopb  out  PAR_W  read parity
- coll_rd  out  1  a read collided with a write of the other port
- coll_wr  out  1  both ports wrote overlapping bytes of the same word
- coll_cnt  out  16  saturating count of collision events

## Operation

- The memory array is not reset. Contents are undefined until written.
- A port is active in a cycle when en=1 at the rising edge of clk. When the port is inactive, its output pipeline holds.
- A write stores the enabled bytes and their parity bits at the port address. Disabled bytes keep their old contents.
- Read data depends on READ_MODE:
  - WRITE_FIRST: the port returns the word after its own write merge.
  - READ_FIRST: the port returns the old word.
  - NO_CHANGE: the output latch holds on any cycle where the port has a nonzero we.
- SSR: when en=1 and ssr=1, the output latch loads SRVAL, overriding the read. A write in the same cycle still updates memory.
- With OUT_REG=1, the second stage loads from the first whenever en=1. SSR resets both stages in the same cycle.
- Read collision:
  - Trigger: both ports active, same address, one port writing, the other port has we=0.
  - The reading port returns the old word for READ_FIRST and the new merged word otherwise.
  - coll_rd pulses.
- Write collision:
  - Trigger: both ports active, same address, both writing.
  - Bytes written by both ports take port A's value. Non-overlapping bytes merge.
  - coll_wr pulses only if the byte enable sets overlap.
  - Each port's read data follows its own READ_MODE against the final merged word.
- coll_cnt increments by 1 per cycle in which coll_rd or coll_wr is asserted. It saturates at 0xFFFF.

## Timing

- Read latency: 1 cycle when OUT_REG=0; 2 cycles when OUT_REG=1.
- A write is visible to a read on either port issued the next cycle.
- coll_rd and coll_wr are registered. They assert for exactly one cycle, one cycle after the colliding edge, independent of OUT_REG.
- coll_cnt updates on the same edge that registers the flag.
- Reset (rst_n=0, asynchronous):
  - doa, dopa, dob and dopb go to SRVAL.
  - All pipeline stages go to SRVAL.
  - coll_rd=0, coll_wr=0, coll_cnt=0.
- A reset in the middle of a pipelined read discards the in-flight data. After release, outputs stay SRVAL until a new read completes.
- A write issued on the edge where reset is asserted is not guaranteed to land in memory.
- Deassertion of rst_n is synchronised by the caller. The block samples nothing on the first edge after release where rst_n was low at setup time.

## Test plan

- Basic write then read, OUT_REG=0, WRITE_FIRST:
  - Stimulus: A writes 0x1234/par 0x3 to addr 5 with wea=11; B reads addr 5 the next cycle.
  - Required: dob=0x1234 and dopb=0x3 one cycle after the read.
- Byte merge:
  - Stimulus: write 0xAABB to addr 7, then write 0x00CC with wea=01, then read.
  - Required: read returns 0xAACC.
- Read-mode collision:
  - Stimulus: addr 3 holds 0x1111. A writes 0x2222 and B reads addr 3 in the same cycle.
  - Required: READ_FIRST gives dob=0x1111; WRITE_FIRST gives dob=0x2222. coll_rd=1 for one cycle and coll_cnt=1.
- Write-write collision:
  - Stimulus: same address; A writes 0xAAAA with wea=11, B writes 0xBBBB with web=01.
  - Required: memory word is 0xAAAA and coll_wr=1.
  - Stimulus: repeat with wea=10 and web=01.
  - Required: word is 0xAABB and coll_wr=0.
- SSR, NO_CHANGE and OUT_REG=1:
  - Stimulus: SRVAL=0x3_5A5A. Assert ssra with ena=1.
  - Required: doa=0x5A5A and dopa=0x3 on the next edge.
  - Stimulus: under NO_CHANGE, perform a write.
  - Required: the output holds its previous value.
  - Stimulus: with OUT_REG=1, perform a read.
  - Required: data appears 2 cycles later.
- Async reset mid-read and counter saturation:
  - Stimulus: drop rst_n between the two stages of an OUT_REG=1 read.
  - Required: outputs go to SRVAL immediately and stale data never appears.
  - Stimulus: force 65540 consecutive collisions.
  - Required: coll_cnt=0xFFFF.

Source files
------------

// File: rtl/ram_tdp_sync.sv
// ram_tdp_sync: single-clock true-dual-port RAM with byte enables, per-byte
// parity, selectable read mode, optional output register, and deterministic
// collision resolution with registered collision flags and a saturating count.
module ram_tdp_sync #(
    parameter int                         ADDR_W    = 10,
    parameter int                         DATA_W    = 16,
    parameter int                         PAR_W     = 2,
    parameter string                      READ_MODE = "WRITE_FIRST",
    parameter int                         OUT_REG   = 0,
    parameter logic [DATA_W+PAR_W-1:0]    SRVAL     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  enb,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [DATA_W/8-1:0]   web,
    input  logic                  ssra,
    input  logic                  ssrb,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [ADDR_W-1:0]     addrb,
    input  logic [DATA_W-1:0]     dia,
    input  logic [DATA_W-1:0]     dib,
    input  logic [PAR_W-1:0]      dipa,
    input  logic [PAR_W-1:0]      dipb,
    output logic [DATA_W-1:0]     doa,
    output logic [DATA_W-1:0]     dob,
    output logic [PAR_W-1:0]      dopa,
    output logic [PAR_W-1:0]      dopb,
    output logic                  coll_rd,
    output logic                  coll_wr,
    output logic [15:0]           coll_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int W     = DATA_W + PAR_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit MODE_RF = (READ_MODE == "READ_FIRST");
    localparam bit MODE_NC = (READ_MODE == "NO_CHANGE");

    // Stored word layout is {parity, data}; parity bit i belongs to byte i.
    logic [W-1:0] mem_q [0:DEPTH-1];

    // Port-indexed views (index 0 = port A, 1 = port B).
    logic [1:0]             en_p;
    logic [1:0]             ssr_p;
    logic [1:0]             wr_p;
    logic [1:0][NB-1:0]     we_p;
    logic [1:0][ADDR_W-1:0] addr_p;
    logic [1:0][W-1:0]      wdat_p;
    logic [1:0][W-1:0]      mask_p;
    logic [1:0][W-1:0]      old_p;
    logic [1:0][W-1:0]      merged_p;
    logic [1:0][W-1:0]      dout_p;

    logic         same_addr;
    logic [W-1:0] xmask_a;
    logic [W-1:0] xmask_b;
    logic         coll_rd_d;
    logic         coll_wr_d;
    logic         coll_rd_q;
    logic         coll_wr_q;
    logic [15:0]  coll_cnt_q;

    assign en_p   = {enb, ena};
    assign ssr_p  = {ssrb, ssra};
    assign we_p   = {web, wea};
    assign addr_p = {addrb, addra};
    assign wdat_p = {{dipb, dib}, {dipa, dia}};

    genvar gi, gl;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port_dec
            // A port only writes when it is enabled and at least one byte is selected.
            assign wr_p[gi]  = en_p[gi] & (|we_p[gi]);
            assign old_p[gi] = mem_q[addr_p[gi]];
            for (gl = 0; gl < NB; gl++) begin : g_lane
                assign mask_p[gi][8*gl +: 8] = {8{en_p[gi] & we_p[gi][gl]}};
                if (PAR_W > 0) begin : g_par
                    assign mask_p[gi][DATA_W + gl] = en_p[gi] & we_p[gi][gl];
                end
            end
        end
    endgenerate

    // Both ports active on one word: each sees the other's byte mask.
    assign same_addr = en_p[0] & en_p[1] & (addr_p[0] == addr_p[1]);
    assign xmask_a   = same_addr ? mask_p[0] : '0;
    assign xmask_b   = same_addr ? mask_p[1] : '0;

    // Final word per port. Port A wins overlapping bytes; when both ports hit
    // the same word the two expressions produce the identical merged value.
    assign merged_p[0] = (old_p[0] & ~mask_p[0] & ~xmask_b)
                       | (wdat_p[0] & mask_p[0])
                       | (wdat_p[1] & xmask_b & ~mask_p[0]);
    assign merged_p[1] = (old_p[1] & ~mask_p[1] & ~xmask_a)
                       | (wdat_p[0] & xmask_a)
                       | (wdat_p[1] & mask_p[1] & ~xmask_a);

    assign coll_rd_d = same_addr & (wr_p[0] ^ wr_p[1]);
    assign coll_wr_d = same_addr & (|(we_p[0] & we_p[1]));

    // Memory update: same-address writes store the same merged word twice.
    always_ff @(posedge clk) begin
        if (wr_p[0]) mem_q[addr_p[0]] <= merged_p[0];
        if (wr_p[1]) mem_q[addr_p[1]] <= merged_p[1];
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port_out
            logic [W-1:0] s1_q;
            logic [W-1:0] s1_d;

            // Output latch selection: SSR first, then NO_CHANGE hold, then read mode.
            always_comb begin
                s1_d = s1_q;
                if (ssr_p[gi])                s1_d = SRVAL;
                else if (MODE_NC && wr_p[gi]) s1_d = s1_q;
                else if (MODE_RF)             s1_d = old_p[gi];
                else                          s1_d = merged_p[gi];
            end

            // First output stage; holds whenever the port is disabled.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)            s1_q <= SRVAL;
                else if (en_p[gi])     s1_q <= s1_d;
            end

            if (OUT_REG != 0) begin : g_oreg
                logic [W-1:0] s2_q;
                // Second stage follows the first while enabled; SSR clears both together.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)        s2_q <= SRVAL;
                    else if (en_p[gi]) s2_q <= ssr_p[gi] ? SRVAL : s1_q;
                end
                assign dout_p[gi] = s2_q;
            end else begin : g_direct
                assign dout_p[gi] = s1_q;
            end
        end
    endgenerate

    // Collision flags are one-cycle registered pulses; the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_rd_q  <= 1'b0;
            coll_wr_q  <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_rd_q <= coll_rd_d;
            coll_wr_q <= coll_wr_d;
            if ((coll_rd_d | coll_wr_d) && (coll_cnt_q != 16'hFFFF))
                coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign doa      = dout_p[0][DATA_W-1:0];
    assign dopa     = dout_p[0][W-1:DATA_W];
    assign dob      = dout_p[1][DATA_W-1:0];
    assign dopb     = dout_p[1][W-1:DATA_W];
    assign coll_rd  = coll_rd_q;
    assign coll_wr  = coll_wr_q;
    assign coll_cnt = coll_cnt_q;

endmodule
